muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide unit with its own sequencing FSM, serving RV32M instructions (opcode OP_R_TYPE, funct7 = 0000001) in the EX stage. It accepts one operation at a time from EX and raises `stall` to freeze IF/ID/EX while it iterates. It pulses `done` with the result so EX can forward it to MEM. Branch/jump redirects abort it through `kill`.

## Interface
- `XLEN`, 32: operand and result width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: EX holds an M-extension instruction. Level signal, held high by EX while stalled.
- `op` in 3: funct3.
  - Multiply: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - Divide: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` in XLEN: rs1 value (dividend / multiplicand).
- `b` in XLEN: rs2 value (divisor / multiplier).
- `kill` in 1: flush of the EX instruction; aborts the operation.
- `result` out XLEN: registered result, valid when `done`=1, held until the next completion.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: state ≠ IDLE.
- `stall` out 1: pipeline hold request to the hazard logic.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If `kill`=0 and `start`=1: latch `op`, |a|, |b| (magnitudes per signedness), sign flags, and clear the 5-bit counter.
  - Next state is DONE for a divide special case, otherwise CALC.
- CALC: one iteration per cycle; counter 0..31; leaves to FIX after count 31.
  - Multiply: radix-2 shift-add on the unsigned magnitudes into a 64-bit product register.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
- FIX: single cycle. Apply sign correction (two's-complement negate) and select the output:
  - MUL: low 32 bits of the product.
  - MULH / MULHSU / MULHU: high 32 bits.
  - Signedness: MULH treats both operands as signed; MULHSU treats `a` as signed, `b` unsigned; MULHU treats both as unsigned.
  - Product is negative iff the operand signs differ (unsigned operand counts as positive).
  - Quotient is negative iff the signs differ. Remainder takes the dividend's sign.
- DONE: `done`=1 with `result` valid. Next state is IDLE unconditionally.
- Divide special cases are decided in IDLE and bypass CALC/FIX:
  - `b`=0: quotient = all ones; remainder = `a`.
  - DIV/REM with `a`=0x80000000 and `b`=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- `kill`=1 in any state returns the FSM to IDLE at the next edge:
  - `done` is not asserted and `result` is unchanged.
  - In IDLE, `kill` has priority over `start`.
- Multiply has no special cases; x·0 iterates normally.
- All arithmetic is modulo 2^XLEN (2^2·XLEN for the product register). There is no overflow flag.

## Timing
- Reset: state = IDLE, counter = 0, `result` = 0, `done` = 0, `busy` = 0, `stall` = 0.
- `stall` = (IDLE & `start` & ~`kill`) | CALC | FIX. It is combinational from `start`/`kill` in IDLE and registered-state-only otherwise.
- Normal op with `start` first high in cycle N:
  - CALC occupies cycles N+1..N+32; FIX is cycle N+33; DONE is cycle N+34.
  - `stall` is high in cycles N..N+33 (34 cycles) and low in N+34, so the pipeline advances in the same cycle `done` is seen.
- Special-case divide: DONE in cycle N+1; `stall` high in cycle N only.
- Back-to-back: if the next M-instruction enters EX in cycle N+35, it is accepted there (IDLE). There is no dead cycle beyond DONE.
- `start` while busy is ignored (EX holds it by contract).
- `start` low in IDLE leaves the FSM idle with `stall`=0.
- `rst` mid-operation behaves like `kill` but also clears `result`. Reset has priority over `kill` and `start`.
- `done` is never high for two consecutive cycles.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), `start` in cycle 0 -> `stall` high cycles 0..33; `done`=1 in cycle 34 with `result`=0xFFFFFFEB; `done`=0 in cycle 35.
- MULH 0x80000000·0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF·0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MUL of the same operands -> 0x00000001.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU 7/0xFFFFFFFF -> 7. Each completes in 34 cycles.
- DIVU 5/0 -> 0xFFFFFFFF with `done` in cycle 1 and `stall` high only in cycle 0. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each is 1-cycle latency.
- MUL started in cycle 0, `kill` in cycle 10 -> `busy`=0 in cycle 11, no `done`, `result` holds its prior value. A new DIVU 100/7 started in cycle 11 -> `done` in cycle 45 with `result`=14.
- `rst` asserted in cycle 20 of a DIV -> cycle 21: `busy`=0, `stall`=0, `result`=0, `done`=0. Back-to-back MUL 3·4 then MUL 5·6 with `start` in cycles 0 and 35 -> `done` in cycles 34 and 69 with 12 and 30.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the EX stage and the iterative mul/div unit.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic [XLEN-1:0] result;
    logic            done;
    logic            busy;
    logic            stall;

    // EX stage side
    modport master (
        output start, op, a, b, kill,
        input  result, done, busy, stall
    );

    // Mul/div unit side
    modport slave (
        input  start, op, a, b, kill,
        output result, done, busy, stall
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected in a final cycle.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    muldiv_sequencer_if.slave  bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   m_q, m_d;       // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;   // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
    logic              sa_q, sa_d;     // operand a negative (signed interpretation only)
    logic              sb_q, sb_d;     // operand b negative (signed interpretation only)
    logic [XLEN-1:0]   result_q, result_d;

    // Issue-time decode
    logic              is_div, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    // Iteration datapath
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    // Sign-correction datapath
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    // Next-state, datapath iteration and result selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        m_d      = m_q;
        acc_d    = acc_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;

        is_div   = bus.op[2];
        a_signed = is_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
        b_signed = is_div ? ~bus.op[0] : ~bus.op[1];
        neg_a    = a_signed & bus.a[XLEN-1];
        neg_b    = b_signed & bus.b[XLEN-1];
        abs_a    = neg_a ? -bus.a : bus.a;
        abs_b    = neg_b ? -bus.b : bus.b;
        div_zero = is_div & (bus.b == '0);
        div_ovf  = is_div & ~bus.op[0] & (bus.a == INT_MIN) & (bus.b == '1);
        if (bus.op[1])
            special_res = div_zero ? bus.a : '0;
        else
            special_res = div_zero ? '1 : INT_MIN;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_q};

        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        if (bus.kill) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_d  = bus.op;
                        sa_d  = neg_a;
                        sb_d  = neg_b;
                        cnt_d = '0;
                        if (is_div) begin
                            m_d   = abs_b;
                            acc_d = {{XLEN{1'b0}}, abs_a};
                        end else begin
                            m_d   = abs_a;
                            acc_d = {{XLEN{1'b0}}, abs_b};
                        end
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (op_q[2]) begin
                        if (!div_diff[XLEN])
                            acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                        else
                            acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_d = S_FIX;
                end
                S_FIX: begin
                    unique case (op_q)
                        3'b000:                 result_d = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = quo_fix;
                        default:                result_d = rem_fix;
                    endcase
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = (state_q == S_DONE);
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.stall  = ((state_q == S_IDLE) & bus.start & ~bus.kill)
                      | (state_q == S_CALC) | (state_q == S_FIX);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    muldiv_sequencer_if #(.XLEN(32)) mif ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Caller is positioned just after a rising edge (start of cycle 0).
    // Returns positioned just after the edge ending cycle 'lat'.
    task automatic run_op(input logic [2:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          input logic [31:0] exp_v, input int lat, input string name);
        int          stall_bad;
        int          done_bad;
        logic [31:0] res_at_done;
        stall_bad   = 0;
        done_bad    = 0;
        res_at_done = 'x;
        mif.op    = op_v;
        mif.a     = a_v;
        mif.b     = b_v;
        mif.kill  = 1'b0;
        mif.start = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            if (mif.stall !== (c < lat)) stall_bad++;
            if (mif.done !== (c == lat)) done_bad++;
            if (c == lat) res_at_done = mif.result;
            @(posedge clk);
            #1;
            if (c + 1 >= lat) mif.start = 1'b0;
        end
        total_cnt++;
        if (stall_bad !== 0)
            $display("FAIL %s stall: %0d cycles wrong, required 0", name, stall_bad);
        else
            pass_cnt++;
        total_cnt++;
        if (done_bad !== 0)
            $display("FAIL %s done timing: %0d cycles wrong, required 0", name, done_bad);
        else
            pass_cnt++;
        total_cnt++;
        if (res_at_done !== exp_v)
            $display("FAIL %s result: got %h, required %h", name, res_at_done, exp_v);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mif.start = 1'b0;
        mif.kill  = 1'b0;
        mif.op    = 3'b000;
        mif.a     = '0;
        mif.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (mif.result !== 32'h0) $display("FAIL reset result: got %h, required 00000000", mif.result);
        else pass_cnt++;
        total_cnt++;
        if (mif.done !== 1'b0) $display("FAIL reset done: got %b, required 0", mif.done);
        else pass_cnt++;
        total_cnt++;
        if (mif.busy !== 1'b0) $display("FAIL reset busy: got %b, required 0", mif.busy);
        else pass_cnt++;
        total_cnt++;
        if (mif.stall !== 1'b0) $display("FAIL idle no-start stall: got %b, required 0", mif.stall);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3");
        run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh_min");
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_max");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_m1");
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, "mul_m1_m1");
        run_op(3'b000, 32'h12345678, 32'h0,        32'h00000000, 34, "mul_zero");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2");
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2");
        run_op(3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34, "divu_big_2");
        run_op(3'b111, 32'd7,        32'hFFFFFFFF, 32'd7,        34, "remu_7_max");
    endtask

    task automatic test_div_special();
        run_op(3'b101, 32'd5,        32'h0,        32'hFFFFFFFF, 1, "divu_by0");
        run_op(3'b110, 32'd5,        32'h0,        32'd5,        1, "rem_by0");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf");
    endtask

    task automatic test_kill();
        int done_seen;
        // kill beats start while idle
        mif.op    = 3'b000;
        mif.a     = 32'd3;
        mif.b     = 32'd3;
        mif.start = 1'b1;
        mif.kill  = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (mif.stall !== 1'b0) $display("FAIL kill_idle stall: got %b, required 0", mif.stall);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (mif.busy !== 1'b0) $display("FAIL kill_idle busy: got %b, required 0", mif.busy);
        else pass_cnt++;
        mif.kill  = 1'b0;
        mif.start = 1'b0;
        @(posedge clk);
        #1;
        run_op(3'b101, 32'd5, 32'h0, 32'hFFFFFFFF, 1, "divu_by0_pre");
        // MUL killed mid-iteration in cycle 10
        done_seen = 0;
        mif.op    = 3'b000;
        mif.a     = 32'd7;
        mif.b     = 32'd9;
        mif.start = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) mif.kill = 1'b1;
            @(negedge clk);
            if (mif.done === 1'b1) done_seen++;
            @(posedge clk);
            #1;
        end
        mif.kill  = 1'b0;
        mif.op    = 3'b101;
        mif.a     = 32'd100;
        mif.b     = 32'd7;
        total_cnt++;
        if (mif.busy !== 1'b0) $display("FAIL kill busy: got %b, required 0", mif.busy);
        else pass_cnt++;
        total_cnt++;
        if (mif.result !== 32'hFFFFFFFF) $display("FAIL kill result hold: got %h, required ffffffff", mif.result);
        else pass_cnt++;
        total_cnt++;
        if (done_seen !== 0) $display("FAIL kill done: got %0d pulses, required 0", done_seen);
        else pass_cnt++;
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_after_kill");
    endtask

    task automatic test_rst_mid_op();
        mif.op    = 3'b100;
        mif.a     = 32'd100;
        mif.b     = 32'd3;
        mif.start = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 20) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        mif.start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (mif.busy !== 1'b0) $display("FAIL rst_mid busy: got %b, required 0", mif.busy);
        else pass_cnt++;
        total_cnt++;
        if (mif.stall !== 1'b0) $display("FAIL rst_mid stall: got %b, required 0", mif.stall);
        else pass_cnt++;
        total_cnt++;
        if (mif.result !== 32'h0) $display("FAIL rst_mid result: got %h, required 00000000", mif.result);
        else pass_cnt++;
        total_cnt++;
        if (mif.done !== 1'b0) $display("FAIL rst_mid done: got %b, required 0", mif.done);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 34, "b2b_first");
        run_op(3'b000, 32'd5, 32'd6, 32'd30, 34, "b2b_second");
        @(negedge clk);
        total_cnt++;
        if (mif.done !== 1'b0) $display("FAIL b2b done after: got %b, required 0", mif.done);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_kill();
        test_rst_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
